// File: rtl/sar_search_ctrl.sv
// Successive-approximation search controller: drives trial codes into an external
// combinational comparator and resolves the hidden target MSB-first.
module sar_search_ctrl #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         cmp_eq,
    input  logic         cmp_gt,
    input  logic         cmp_lt,
    output logic [W-1:0] trial,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         match,
    output logic         err
);
    localparam int IDX_W = (W > 1) ? $clog2(W) : 1;
    localparam logic [W-1:0] MSB_CODE = W'(1) << (W - 1);

    typedef enum logic [1:0] {IDLE, TEST, DONE} state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [W-1:0]     bit_mask;
    logic [W-1:0]     trial_upd;
    logic             flags_onehot;

    // bit_mask marks the bit under test; trial_upd is the trial after resolving it
    always_comb begin
        bit_mask     = W'(1) << idx;
        trial_upd    = cmp_gt ? (trial & ~bit_mask) : trial;
        flags_onehot = ({cmp_eq, cmp_gt, cmp_lt} == 3'b100) ||
                       ({cmp_eq, cmp_gt, cmp_lt} == 3'b010) ||
                       ({cmp_eq, cmp_gt, cmp_lt} == 3'b001);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            trial  <= '0;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            match  <= 1'b0;
            err    <= 1'b0;
            idx    <= IDX_W'(W - 1);
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        trial <= MSB_CODE;
                        idx   <= IDX_W'(W - 1);
                        match <= 1'b0;
                        err   <= 1'b0;
                        busy  <= 1'b1;
                        state <= TEST;
                    end
                end
                TEST: begin
                    if (!flags_onehot) begin
                        result <= trial;
                        err    <= 1'b1;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else if (cmp_eq) begin
                        result <= trial;
                        match  <= 1'b1;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else if (idx == '0) begin
                        trial  <= trial_upd;
                        result <= trial_upd;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        // Resolve this bit and tentatively set the next lower one
                        trial <= trial_upd | (bit_mask >> 1);
                        idx   <= idx - IDX_W'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Self-checking bench for sar_search_ctrl: a comparator model holds the target and
// a closed-form reference predicts trials, latency and the resolved result.
module tb_sar_search_ctrl;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] target = '0;
    logic         ovr_en = 1'b0;
    logic [2:0]   ovr_flags = 3'b000;
    logic         cmp_eq, cmp_gt, cmp_lt;
    logic [W-1:0] trial, result;
    logic         busy, done, match, err;

    logic start1 = 1'b0;
    logic target1 = 1'b0;
    logic cmp_eq1, cmp_gt1, cmp_lt1;
    logic trial1, result1, busy1, done1, match1, err1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign {cmp_eq, cmp_gt, cmp_lt} = ovr_en ? ovr_flags :
                                      {trial == target, trial > target, trial < target};
    assign {cmp_eq1, cmp_gt1, cmp_lt1} = {trial1 == target1, trial1 > target1, trial1 < target1};

    sar_search_ctrl #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cmp_eq(cmp_eq), .cmp_gt(cmp_gt), .cmp_lt(cmp_lt),
        .trial(trial), .busy(busy), .done(done),
        .result(result), .match(match), .err(err)
    );

    sar_search_ctrl #(.W(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .cmp_eq(cmp_eq1), .cmp_gt(cmp_gt1), .cmp_lt(cmp_lt1),
        .trial(trial1), .busy(busy1), .done(done1),
        .result(result1), .match(match1), .err(err1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Trial on step s probes bit b=W-s: target bits above b are already known, bit b is set
    function automatic int exp_trial(input int t, input int step);
        int b;
        b = W - step;
        return ((t >> (b + 1)) << (b + 1)) | (1 << b);
    endfunction

    // Equality is hit once all set bits of the target are known, i.e. when its lowest set bit is probed
    function automatic int exp_trials(input int t);
        for (int b = 0; b < W; b++)
            if (t[b]) return W - b;
        return W;
    endfunction

    task automatic search(input int t, input bit pulse_mid);
        int step;
        target = t;
        start = 1'b1;
        tick;
        start = 1'b0;
        step = 1;
        while (!done && step <= W + 2) begin
            check("busy_test", busy, 1);
            if (step <= W) check("trial", trial, exp_trial(t, step));
            if (pulse_mid) start = (step == 2);
            step++;
            tick;
        end
        start = 1'b0;
        check("done_seen", done, 1);
        check("latency", step - 1, exp_trials(t));
        check("result", result, t);
        check("match", match, (t != 0));
        check("err", err, 0);
        check("busy_in_done", busy, 0);
        tick;
        check("done_one_cycle", done, 0);
        check("busy_after", busy, 0);
    endtask

    initial begin
        #2;
        check("rst_trial", trial, 0);
        check("rst_result", result, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_match", match, 0);
        check("rst_err", err, 0);
        check("rst_trial_w1", trial1, 0);
        #10 rst_n = 1'b1;
        tick;

        search(5, 1'b0);
        search(0, 1'b0);
        search(15, 1'b0);
        search(8, 1'b0);
        for (int i = 0; i < 10; i++) search(int'($urandom_range(0, (1 << W) - 1)), 1'b0);
        search(5, 1'b1);

        // Illegal flag pattern on the 2nd trial
        target = 13;
        start = 1'b1;
        tick;
        start = 1'b0;
        check("err_trial1", trial, 8);
        tick;
        check("err_trial2", trial, 12);
        ovr_en = 1'b1;
        ovr_flags = 3'b110;
        tick;
        ovr_en = 1'b0;
        check("err_done", done, 1);
        check("err_flag", err, 1);
        check("err_result", result, 12);
        check("err_match", match, 0);
        tick;
        check("err_done_clear", done, 0);

        // start held high: relaunch in the IDLE cycle after DONE
        target = 8;
        start = 1'b1;
        tick;
        check("hold_busy1", busy, 1);
        tick;
        check("hold_done1", done, 1);
        tick;
        check("hold_idle_busy", busy, 0);
        check("hold_idle_done", done, 0);
        tick;
        check("hold_busy2", busy, 1);
        check("hold_trial2", trial, 8);
        start = 1'b0;
        tick;
        check("hold_done2", done, 1);
        check("hold_result2", result, 8);
        tick;

        // Asynchronous reset mid-search
        target = 5;
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        check("mid_trial2", trial, 4);
        #2 rst_n = 1'b0;
        #1;
        check("arst_trial", trial, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_result", result, 0);
        check("arst_match", match, 0);
        check("arst_err", err, 0);
        tick;
        check("arst_no_done", done, 0);
        #2 rst_n = 1'b1;
        tick;
        check("arst_still_idle", done, 0);
        search(9, 1'b0);

        // W=1 boundary
        target1 = 1'b0;
        start1 = 1'b1;
        tick;
        start1 = 1'b0;
        check("w1_trial", trial1, 1);
        check("w1_busy", busy1, 1);
        tick;
        check("w1_done_gt", done1, 1);
        check("w1_result_gt", result1, 0);
        check("w1_match_gt", match1, 0);
        check("w1_err_gt", err1, 0);
        tick;
        target1 = 1'b1;
        start1 = 1'b1;
        tick;
        start1 = 1'b0;
        tick;
        check("w1_done_eq", done1, 1);
        check("w1_result_eq", result1, 1);
        check("w1_match_eq", match1, 1);
        tick;
        check("w1_done_clear", done1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
